rom_addr_seq: RTL and testbench

Address sequencer and read-data capture stage placed directly upstream and downstream of the single-port ROM (8-bit address, 8-bit q, registered address and output). It generates the ROM read address over a programmable window [start_addr, end_addr] with a programmable stride, in single-pass or loop mode. It tracks the ROM read latency and presents each returned word with a valid flag and a last flag. This replaces the hand-written address-ramp stimulus and serves as the playback engine for on-chip logic-analyser capture.

---
 rtl/rom_seq_pkg.sv | 15 +
 rtl/rom_seq_tagpipe.sv | 43 ++++
 rtl/rom_addr_seq.sv | 162 ++++++++++++++++
 tb/tb_rom_addr_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// Shared types and defaults for the ROM address sequencer.
package rom_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int ROM_LAT_DEF = 2;
    localparam int ROM_LAT_MAX = 4;

endpackage

// File: rtl/rom_seq_tagpipe.sv
// LAT-deep {valid,last} shift register that tracks words in flight through the ROM.
// mark_last retro-tags the youngest in-flight word as the final one.
module rom_seq_tagpipe
    import rom_seq_pkg::*;
#(
    parameter int LAT = ROM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    input  logic mark_last,
    output logic head_valid,
    output logic head_last,
    output logic empty
);

    logic [LAT:1] v;
    logic [LAT:1] l;
    logic         last1_eff;

    // Stage 1 always holds the word issued on the previous cycle.
    assign last1_eff = l[1] | mark_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            l <= '0;
        end else begin
            v[1] <= in_valid;
            l[1] <= in_last;
            for (int k = 2; k <= LAT; k++) begin
                v[k] <= v[k-1];
                l[k] <= (k == 2) ? last1_eff : l[k-1];
            end
        end
    end

    assign head_valid = v[LAT];
    assign head_last  = (LAT == 1) ? last1_eff : l[LAT];
    assign empty      = ~|v;

endmodule

// File: rtl/rom_addr_seq.sv
// ROM address sequencer and read-data capture stage.
// Optional pass counter output enabled by defining ROM_SEQ_PASSCNT_EN.
module rom_addr_seq
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy,
    output logic              done
`ifdef ROM_SEQ_PASSCNT_EN
    ,
    output logic [15:0]       pass_cnt
`endif
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [ADDR_W-1:0] cfg_start;
    logic [ADDR_W-1:0] cfg_end;
    logic [ADDR_W-1:0] cfg_step;
    logic              cfg_loop;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W:0]   nxt;
    logic              pass_end;
    logic              cfg_load;
    logic              issue;
    logic              issue_last;
    logic              mark_last;
    logic              finish;
    logic              head_valid;
    logic              head_last;
    logic              pipe_empty;

    // One extra bit so an address past the top of the ROM is seen, not wrapped.
    assign nxt      = {1'b0, rom_addr} + {1'b0, cfg_step};
    assign pass_end = nxt > {1'b0, cfg_end};

    always_comb begin
        state_nxt  = state;
        addr_nxt   = rom_addr;
        cfg_load   = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        mark_last  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cfg_load  = 1'b1;
                    addr_nxt  = start_addr;
                end
            end
            RUN: begin
                if (stop) begin
                    mark_last = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (pass_end) begin
                        if (cfg_loop) begin
                            addr_nxt = cfg_start;
                        end else begin
                            issue_last = 1'b1;
                            state_nxt  = DRAIN;
                        end
                    end else begin
                        addr_nxt = nxt[ADDR_W-1:0];
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            cfg_start <= '0;
            cfg_end   <= '0;
            cfg_step  <= '0;
            cfg_loop  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rom_addr <= addr_nxt;
            done     <= finish;
            if (cfg_load) begin
                cfg_start <= start_addr;
                cfg_end   <= end_addr;
                cfg_step  <= (step == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : step;
                cfg_loop  <= loop;
                busy      <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

    rom_seq_tagpipe #(
        .LAT(ROM_LAT)
    ) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_last   (issue_last),
        .mark_last (mark_last),
        .head_valid(head_valid),
        .head_last (head_last),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= head_valid;
            dout_last  <= head_valid & head_last;
            if (head_valid) begin
                dout <= rom_q;
            end
        end
    end

`ifdef ROM_SEQ_PASSCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (cfg_load) begin
            pass_cnt <= '0;
        end else if (issue && pass_end && cfg_loop && (pass_cnt != 16'hFFFF)) begin
            pass_cnt <= pass_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_addr_seq.sv
// Directed bench for rom_addr_seq with a 2-cycle ROM model (q = addr).
module tb_rom_addr_seq;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [7:0] start_addr = '0;
    logic [7:0] end_addr = '0;
    logic [7:0] step = '0;
    logic [7:0] rom_addr;
    logic [7:0] rom_q = '0;
    logic [7:0] rom_areg = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       busy;
    logic       done;
`ifdef ROM_SEQ_PASSCNT_EN
    logic [15:0] pass_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    rom_addr_seq #(
        .ADDR_W (8),
        .DATA_W (8),
        .ROM_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .step      (step),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
`ifdef ROM_SEQ_PASSCNT_EN
        ,
        .pass_cnt  (pass_cnt)
`endif
    );

    // Clock / ROM model / cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_areg <= rom_addr;
        rom_q    <= rom_areg;
    end

    // Output log: every delivered word and every done pulse
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            got_d.push_back(dout);
            got_l.push_back(dout_last);
            got_cyc.push_back(cyc);
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic pulse_start(input logic [7:0] sa, input logic [7:0] ea,
                               input logic [7:0] st, input logic lp);
        @(negedge clk);
        start_addr = sa;
        end_addr   = ea;
        step       = st;
        loop       = lp;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last got=%b exp=0", dout_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy=%b valid=%b exp=0/0", busy, dout_valid); end
    endtask

    task automatic test_full_ramp();
        bit ok;
        clear_log();
        for (int a = 0; a < 256; a++) exp_q.push_back(8'(a));
        pulse_start(8'd0, 8'd255, 8'd1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_rise got=%b exp=1", busy); end
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout got=no_done exp=done"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_fall got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_width got=%b exp=0", done); end
        checks++; if (got_d.size() !== exp_q.size()) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", got_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_q[i]) begin errors++; $display("FAIL ramp_word[%0d] got=%0d exp=%0d", i, got_d[i], exp_q[i]); end
            checks++; if (got_l[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL ramp_last[%0d] got=%b exp=%b", i, got_l[i], i == exp_q.size() - 1); end
        end
        if (got_cyc.size() > 0) begin
            checks++; if (done_cyc !== got_cyc[got_cyc.size()-1] + 1) begin errors++; $display("FAIL ramp_done_timing got=%0d exp=%0d", done_cyc, got_cyc[got_cyc.size()-1] + 1); end
        end
        checks++; if (rom_addr !== 8'd255) begin errors++; $display("FAIL ramp_addr_hold got=%0d exp=255", rom_addr); end
    endtask

    task automatic test_stride();
        bit ok;
        int c0;
        clear_log();
        exp_q = '{8'd10, 8'd13, 8'd16, 8'd19};
        pulse_start(8'd10, 8'd20, 8'd3, 1'b0);
        c0 = cyc;
        checks++; if (rom_addr !== 8'd10) begin errors++; $display("FAIL stride_first_addr got=%0d exp=10", rom_addr); end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stride_timeout got=no_done exp=done"); end
        @(negedge clk);
        checks++; if (got_d.size() !== exp_q.size()) begin errors++; $display("FAIL stride_count got=%0d exp=%0d", got_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_q[i]) begin errors++; $display("FAIL stride_word[%0d] got=%0d exp=%0d", i, got_d[i], exp_q[i]); end
            checks++; if (got_l[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL stride_last[%0d] got=%b exp=%b", i, got_l[i], i == exp_q.size() - 1); end
        end
        if (got_cyc.size() > 0) begin
            checks++; if (got_cyc[0] - c0 !== LAT + 1) begin errors++; $display("FAIL stride_latency got=%0d exp=%0d", got_cyc[0] - c0, LAT + 1); end
        end
        checks++; if (rom_addr !== 8'd19) begin errors++; $display("FAIL stride_addr_hold got=%0d exp=19", rom_addr); end
    endtask

    task automatic test_no_overflow();
        bit ok;
        clear_log();
        pulse_start(8'd100, 8'd255, 8'd200, 1'b0);
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL novf_timeout got=no_done exp=done"); end
        @(negedge clk);
        checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL novf_count got=%0d exp=1", got_d.size()); end
        if (got_d.size() > 0) begin
            checks++; if (got_d[0] !== 8'd100 || got_l[0] !== 1'b1) begin errors++; $display("FAIL novf_word got=%0d/%b exp=100/1", got_d[0], got_l[0]); end
        end
        checks++; if (rom_addr !== 8'd100) begin errors++; $display("FAIL novf_addr got=%0d exp=100", rom_addr); end
    endtask

    task automatic test_loop_stop();
        bit ok;
        clear_log();
        exp_q = '{8'd250, 8'd254, 8'd250, 8'd254, 8'd250};
        pulse_start(8'd250, 8'd255, 8'd4, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (rom_addr !== 8'd254) begin errors++; $display("FAIL loop_sixth_addr got=%0d exp=254", rom_addr); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loop_timeout got=no_done exp=done"); end
        @(negedge clk);
        checks++; if (got_d.size() !== exp_q.size()) begin errors++; $display("FAIL loop_count got=%0d exp=%0d", got_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_q[i]) begin errors++; $display("FAIL loop_word[%0d] got=%0d exp=%0d", i, got_d[i], exp_q[i]); end
            checks++; if (got_l[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL loop_last[%0d] got=%b exp=%b", i, got_l[i], i == exp_q.size() - 1); end
        end
`ifdef ROM_SEQ_PASSCNT_EN
        checks++; if (pass_cnt !== 16'd2) begin errors++; $display("FAIL loop_pass_cnt got=%0d exp=2", pass_cnt); end
`endif
    endtask

    task automatic test_step0_restart();
        bit ok;
        clear_log();
        exp_q = '{8'd5, 8'd6, 8'd7};
        pulse_start(8'd5, 8'd7, 8'd0, 1'b0);
        @(negedge clk);
        start_addr = 8'd100;
        end_addr   = 8'd200;
        step       = 8'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL step0_timeout got=no_done exp=done"); end
        repeat (10) @(negedge clk);
        checks++; if (got_d.size() !== exp_q.size()) begin errors++; $display("FAIL step0_count got=%0d exp=%0d", got_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_q[i]) begin errors++; $display("FAIL step0_word[%0d] got=%0d exp=%0d", i, got_d[i], exp_q[i]); end
            checks++; if (got_l[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL step0_last[%0d] got=%b exp=%b", i, got_l[i], i == exp_q.size() - 1); end
        end
        checks++; if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL step0_no_restart done_cnt=%0d busy=%b exp=1/0", done_cnt, busy); end
    endtask

    task automatic test_start_stop_same();
        bit ok;
        clear_log();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt !== 0) begin errors++; $display("FAIL idle_stop busy=%b done_cnt=%0d exp=0/0", busy, done_cnt); end
        exp_q = '{8'd10, 8'd11, 8'd12};
        start_addr = 8'd10;
        end_addr   = 8'd12;
        step       = 8'd1;
        loop       = 1'b0;
        start      = 1'b1;
        stop       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL both_timeout got=no_done exp=done"); end
        @(negedge clk);
        checks++; if (got_d.size() !== exp_q.size()) begin errors++; $display("FAIL both_count got=%0d exp=%0d", got_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_q[i]) begin errors++; $display("FAIL both_word[%0d] got=%0d exp=%0d", i, got_d[i], exp_q[i]); end
            checks++; if (got_l[i] !== (i == exp_q.size() - 1)) begin errors++; $display("FAIL both_last[%0d] got=%b exp=%b", i, got_l[i], i == exp_q.size() - 1); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start(8'd0, 8'd255, 8'd1, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL rstmid_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL rstmid_dout got=%0d exp=0", dout); end
        checks++; if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin errors++; $display("FAIL rstmid_flags valid=%b last=%b exp=0/0", dout_valid, dout_last); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done busy=%b done=%b exp=0/0", busy, done); end
        clear_log();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL rstmid_no_output got=%0d exp=0", got_d.size()); end
        checks++; if (busy !== 1'b0 || rom_addr !== 8'd0) begin errors++; $display("FAIL rstmid_idle busy=%b rom_addr=%0d exp=0/0", busy, rom_addr); end
    endtask

    initial begin
        test_reset();
        test_full_ramp();
        test_stride();
        test_no_overflow();
        test_loop_stop();
        test_step0_restart();
        test_start_stop_same();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
